drv_fifo_bank: RTL and testbench

DRV_FIFO_BANK -- requirements
Module: drv_fifo_bank

---
 rtl/drv_fifo_bank_if.sv | 35 +++
 rtl/drv_fifo_bank.sv | 93 +++++++++
 tb/tb_drv_fifo_bank.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/drv_fifo_bank_if.sv
// Signal bundle for drv_fifo_bank.
// The agent/bus side (master) drives the strobes, and the FIFO bank (slave) returns its status and head words.
interface drv_fifo_bank_if #(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8,
  parameter int drvrs     = 4
);
  localparam int CW = $clog2(deep_fifo + 1);

  // Strobe semantics, per channel and per cycle:
  //   push_in writes D_in.
  //   pop acknowledges the word currently on D_pop.
  //   flush clears the channel.
  // Every output is derived from registered state only.
  logic [drvrs-1:0]              push_in;
  logic [drvrs-1:0][pckg_sz-1:0] D_in;
  logic [drvrs-1:0]              flush;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              full;
  logic [drvrs-1:0][CW-1:0]      count;
  logic [drvrs-1:0][15:0]        ovf_cnt;
  logic [drvrs-1:0]              udf_err;

  modport master (
    output push_in, D_in, flush, pop,
    input  pndng, D_pop, full, count, ovf_cnt, udf_err
  );

  modport slave (
    input  push_in, D_in, flush, pop,
    output pndng, D_pop, full, count, ovf_cnt, udf_err
  );
endinterface

// File: rtl/drv_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs, one per bus driver.
// Each FIFO has an overflow counter and a sticky underflow flag.
module drv_fifo_bank #(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8,
  parameter int drvrs     = 4,
  parameter int ovf_mode  = 0
) (
  input  logic           clk,
  input  logic           reset,
  drv_fifo_bank_if.slave bus
);
  localparam int PW = $clog2(deep_fifo);
  localparam int CW = $clog2(deep_fifo + 1);

  // Pointers wrap explicitly because depth need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(deep_fifo - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar g = 0; g < drvrs; g++) begin : g_ch
    logic [pckg_sz-1:0] mem [deep_fifo];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      cnt;
    logic [15:0]        ovf;
    logic               udf;
    logic               is_empty;
    logic               is_full;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(deep_fifo));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        ovf    <= '0;
        udf    <= 1'b0;
        for (int i = 0; i < deep_fifo; i++) mem[i] <= '0;
      end else if (bus.flush[g]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        case ({bus.push_in[g], bus.pop[g]})
          2'b11: begin
            mem[wr_ptr] <= bus.D_in[g];
            wr_ptr      <= nxt(wr_ptr);
            if (is_empty) begin
              cnt <= CW'(1);
              udf <= 1'b1;
            end else begin
              rd_ptr <= nxt(rd_ptr);
            end
          end
          2'b10: begin
            if (!is_full) begin
              mem[wr_ptr] <= bus.D_in[g];
              wr_ptr      <= nxt(wr_ptr);
              cnt         <= cnt + CW'(1);
            end else begin
              if (ovf != 16'hFFFF) ovf <= ovf + 16'd1;
              // When full, wr_ptr == rd_ptr, so this overwrites the oldest word in place.
              if (ovf_mode != 0) begin
                mem[wr_ptr] <= bus.D_in[g];
                wr_ptr      <= nxt(wr_ptr);
                rd_ptr      <= nxt(rd_ptr);
              end
            end
          end
          2'b01: begin
            if (!is_empty) begin
              rd_ptr <= nxt(rd_ptr);
              cnt    <= cnt - CW'(1);
            end else begin
              udf <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    assign bus.pndng[g]   = !is_empty;
    assign bus.full[g]    = is_full;
    assign bus.D_pop[g]   = mem[rd_ptr];
    assign bus.count[g]   = cnt;
    assign bus.ovf_cnt[g] = ovf;
    assign bus.udf_err[g] = udf;
  end
endmodule

// File: tb/tb_drv_fifo_bank.sv
// Bench for drv_fifo_bank: a drop-mode and an overwrite-mode instance share one stimulus.
// Both instances are checked every cycle against queue models, plus directed literal scenarios.
module tb_drv_fifo_bank;
  localparam int PW  = 16;
  localparam int DEP = 8;
  localparam int NCH = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic                  clk;
  logic                  rst;
  logic [NCH-1:0]        push_in;
  logic [NCH-1:0][PW-1:0] d_in;
  logic [NCH-1:0]        flush;
  logic [NCH-1:0]        pop;

  int n_cmp = 0;
  int n_err = 0;

  drv_fifo_bank_if #(.pckg_sz(PW), .deep_fifo(DEP), .drvrs(NCH)) bus0 ();
  drv_fifo_bank_if #(.pckg_sz(PW), .deep_fifo(DEP), .drvrs(NCH)) bus1 ();

  assign bus0.push_in = push_in;
  assign bus0.D_in    = d_in;
  assign bus0.flush   = flush;
  assign bus0.pop     = pop;
  assign bus1.push_in = push_in;
  assign bus1.D_in    = d_in;
  assign bus1.flush   = flush;
  assign bus1.pop     = pop;

  drv_fifo_bank #(.pckg_sz(PW), .deep_fifo(DEP), .drvrs(NCH), .ovf_mode(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );
  drv_fifo_bank #(.pckg_sz(PW), .deep_fifo(DEP), .drvrs(NCH), .ovf_mode(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- output views indexed by mode ----------------
  logic [NCH-1:0]         o_pndng [2];
  logic [NCH-1:0]         o_full  [2];
  logic [NCH-1:0][CW-1:0] o_count [2];
  logic [NCH-1:0][PW-1:0] o_dpop  [2];
  logic [NCH-1:0][15:0]   o_ovf   [2];
  logic [NCH-1:0]         o_udf   [2];

  assign o_pndng[0] = bus0.pndng;   assign o_pndng[1] = bus1.pndng;
  assign o_full[0]  = bus0.full;    assign o_full[1]  = bus1.full;
  assign o_count[0] = bus0.count;   assign o_count[1] = bus1.count;
  assign o_dpop[0]  = bus0.D_pop;   assign o_dpop[1]  = bus1.D_pop;
  assign o_ovf[0]   = bus0.ovf_cnt; assign o_ovf[1]   = bus1.ovf_cnt;
  assign o_udf[0]   = bus0.udf_err; assign o_udf[1]   = bus1.udf_err;

  // ---------------- behavioural model ----------------
  logic [PW-1:0] mq [2][NCH][$];
  int unsigned   movf [2][NCH];
  bit            mudf [2][NCH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < NCH; c++) begin
          mq[m][c].delete();
          movf[m][c] = 0;
          mudf[m][c] = 1'b0;
        end
    end else begin
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < NCH; c++) begin
          if (flush[c]) begin
            mq[m][c].delete();
          end else if (push_in[c] && pop[c]) begin
            if (mq[m][c].size() == 0) mudf[m][c] = 1'b1;
            else void'(mq[m][c].pop_front());
            mq[m][c].push_back(d_in[c]);
          end else if (push_in[c]) begin
            if (mq[m][c].size() < DEP) begin
              mq[m][c].push_back(d_in[c]);
            end else begin
              if (movf[m][c] < 32'hFFFF) movf[m][c]++;
              if (m == 1) begin
                void'(mq[m][c].pop_front());
                mq[m][c].push_back(d_in[c]);
              end
            end
          end else if (pop[c]) begin
            if (mq[m][c].size() == 0) mudf[m][c] = 1'b1;
            else void'(mq[m][c].pop_front());
          end
        end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("m%0d_ch%0d_count", m, c), 32'(o_count[m][c]), 32'(mq[m][c].size()));
        check($sformatf("m%0d_ch%0d_pndng", m, c), 32'(o_pndng[m][c]), 32'(mq[m][c].size() != 0));
        check($sformatf("m%0d_ch%0d_full", m, c), 32'(o_full[m][c]), 32'(mq[m][c].size() == DEP));
        check($sformatf("m%0d_ch%0d_ovf", m, c), 32'(o_ovf[m][c]), movf[m][c]);
        check($sformatf("m%0d_ch%0d_udf", m, c), 32'(o_udf[m][c]), 32'(mudf[m][c]));
        if (mq[m][c].size() != 0)
          check($sformatf("m%0d_ch%0d_dpop", m, c), 32'(o_dpop[m][c]), 32'(mq[m][c][0]));
      end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    push_in = '0;
    pop     = '0;
    flush   = '0;
  endtask

  task automatic write(input int c, input logic [PW-1:0] v);
    push_in[c] = 1'b1;
    d_in[c]    = v;
    cycle();
  endtask

  task automatic random_cycles(input int n, input int push_pct, input int pop_pct);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++) begin
        push_in[c] = ($urandom_range(0, 99) < push_pct);
        pop[c]     = ($urandom_range(0, 99) < pop_pct);
        flush[c]   = ($urandom_range(0, 199) == 0);
        d_in[c]    = PW'($urandom);
      end
      cycle();
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst     = 1'b0;
    push_in = '0;
    pop     = '0;
    flush   = '0;
    d_in    = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_pndng", 32'(bus0.pndng), 32'h0);
    check("reset_count", 32'(bus1.count), 32'h0);
    check("reset_dpop", 32'(bus0.D_pop), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // In-order FIFO 1 traffic.
    write(1, 16'h0202);
    check("f1_count1", 32'(bus0.count[1]), 32'd1);
    check("f1_head_after_first", 32'(bus0.D_pop[1]), 32'h0202);
    write(1, 16'h0103);
    check("f1_count2", 32'(bus0.count[1]), 32'd2);
    write(1, 16'h0204);
    check("f1_count3", 32'(bus0.count[1]), 32'd3);
    check("f1_head", 32'(bus0.D_pop[1]), 32'h0202);
    pop[1] = 1'b1; cycle();
    check("f1_pop2", 32'(bus0.D_pop[1]), 32'h0103);
    pop[1] = 1'b1; cycle();
    check("f1_pop3", 32'(bus0.D_pop[1]), 32'h0204);
    pop[1] = 1'b1; cycle();
    check("f1_empty", 32'(bus0.pndng[1]), 32'h0);

    // Overflow of FIFO 0 in drop and overwrite modes.
    for (int i = 0; i < 10; i++) write(0, PW'(i));
    check("drop_full", 32'(bus0.full[0]), 32'h1);
    check("drop_ovf", 32'(bus0.ovf_cnt[0]), 32'd2);
    check("ovw_count", 32'(bus1.count[0]), 32'd8);
    check("ovw_ovf", 32'(bus1.ovf_cnt[0]), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drop_pop%0d", i), 32'(bus0.D_pop[0]), 32'(i));
      check($sformatf("ovw_pop%0d", i), 32'(bus1.D_pop[0]), 32'(i + 2));
      pop[0] = 1'b1;
      cycle();
    end
    check("drop_drained", 32'(bus0.pndng[0]), 32'h0);

    // A full FIFO 2 under simultaneous push and pop, across pointer wrap.
    for (int i = 0; i < 8; i++) write(2, PW'(16'h0020 + i));
    for (int i = 0; i < 20; i++) begin
      check($sformatf("f2_head%0d", i), 32'(bus0.D_pop[2]), (i < 8) ? 32'(16'h0020 + i) : 32'hAAAA);
      push_in[2] = 1'b1;
      pop[2]     = 1'b1;
      d_in[2]    = 16'hAAAA;
      cycle();
      check($sformatf("f2_count%0d", i), 32'(bus1.count[2]), 32'd8);
      check($sformatf("f2_ovf%0d", i), 32'(bus0.ovf_cnt[2]), 32'd0);
    end
    flush[2] = 1'b1; cycle();

    // Underflow on FIFO 3 survives a flush.
    pop[3] = 1'b1; cycle();
    check("f3_udf", 32'(bus0.udf_err[3]), 32'h1);
    check("f3_count", 32'(bus0.count[3]), 32'h0);
    flush[3] = 1'b1; cycle();
    check("f3_udf_after_flush", 32'(bus1.udf_err[3]), 32'h1);

    // Asynchronous reset asserted mid-cycle while FIFO 0 is partly full.
    for (int i = 0; i < 5; i++) write(0, PW'(16'h00A0 + i));
    check("f0_fill5", 32'(bus0.count[0]), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus0.count[0]), 32'h0);
    check("arst_pndng", 32'(bus1.pndng[0]), 32'h0);
    check("arst_udf", 32'(bus0.udf_err[3]), 32'h0);
    check("arst_dpop", 32'(bus0.D_pop[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_pndng", 32'(bus0.pndng[0]), 32'h0);
    end
    write(0, 16'h1234);
    check("post_rst_write", 32'(bus0.D_pop[0]), 32'h1234);

    // Randomized traffic: fill-heavy, drain-heavy, then balanced.
    random_cycles(600, 80, 30);
    random_cycles(600, 30, 80);
    random_cycles(600, 50, 50);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
